pc_gen: RTL

- Parametrised program-counter generator for the fetch stage; next generation of the core PC register.
- Supplies the fetch address to instruction memory over a req/ready handshake.
- Selects the next PC by priority: exception vector, boot-load address, branch/jump redirect, sequential increment.
- Adds stall, halt, pending-redirect capture and alignment checking.

---
 rtl/pc_pkg.sv | 32 +++
 rtl/pc_next_sel.sv | 89 ++++++++
 rtl/pc_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
// Pending-source encoding doubles as priority rank: larger value wins.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        PEND_NONE  = 2'd0,
        PEND_REDIR = 2'd1,
        PEND_BOOT  = 2'd2,
        PEND_EXC   = 2'd3
    } pend_src_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

    // True when a new event should replace the one held (ties go to the newcomer).
    function automatic logic src_takes_over(input pend_src_e incoming, input pend_src_e held);
        logic take;
        if (incoming != PEND_NONE && incoming >= held) begin
            take = 1'b1;
        end else begin
            take = 1'b0;
        end
        return take;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux over live and pending redirect sources.
// Also reports the decoded live event so the caller can capture it as pending.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned       XLEN    = 32,
    parameter int unsigned       BOOT_W  = 8,
    parameter logic [XLEN-1:0]   EXC_VEC = XLEN'(DEF_EXC_VEC),
    parameter int unsigned       INC     = 4
) (
    input  logic              exc_valid,
    input  logic              boot_load,
    input  logic [BOOT_W-1:0] boot_addr,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  pend_src_e         pend_src,
    input  logic [XLEN-1:0]   pend_pc,
    input  logic [XLEN-1:0]   cur_pc,
    output pend_src_e         live_src,
    output logic [XLEN-1:0]   live_pc,
    output logic [XLEN-1:0]   next_pc,
    output logic              misalign
);

    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    pend_src_e       sel_src_s;
    logic [XLEN-1:0] sel_pc_s;

    // Decode live event inputs into a single highest-priority source.
    always_comb begin
        live_src = PEND_NONE;
        live_pc  = '0;
        if (exc_valid) begin
            live_src = PEND_EXC;
            live_pc  = EXC_VEC;
        end else if (boot_load) begin
            live_src = PEND_BOOT;
            live_pc  = XLEN'(boot_addr);
        end else if (redirect_valid) begin
            live_src = PEND_REDIR;
            live_pc  = redirect_pc;
        end else begin
            live_src = PEND_NONE;
            live_pc  = '0;
        end
    end

    // Merge live with pending (live wins ties), then form the next PC.
    always_comb begin
        sel_src_s = pend_src;
        sel_pc_s  = pend_pc;
        next_pc   = cur_pc + INC_V;
        misalign  = 1'b0;
        if (src_takes_over(live_src, pend_src)) begin
            sel_src_s = live_src;
            sel_pc_s  = live_pc;
        end else begin
            sel_src_s = pend_src;
            sel_pc_s  = pend_pc;
        end
        case (sel_src_s)
            PEND_EXC: begin
                next_pc = EXC_VEC;
            end
            PEND_BOOT: begin
                next_pc = sel_pc_s;
            end
            PEND_REDIR: begin
                // Only branch/jump targets are alignment-checked.
                if ((sel_pc_s & ALIGN_MASK) != '0) begin
                    next_pc  = EXC_VEC;
                    misalign = 1'b1;
                end else begin
                    next_pc  = sel_pc_s;
                    misalign = 1'b0;
                end
            end
            PEND_NONE: begin
                next_pc = cur_pc + INC_V;
            end
            default: begin
                next_pc = cur_pc + INC_V;
            end
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: FSM, pending-event slot and PC register,
// presenting the fetch address to instruction memory over a req/ready handshake.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     BOOT_W    = 8,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEF_EXC_VEC),
    parameter int unsigned     INC       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              halt,
    input  logic              boot_load,
    input  logic [BOOT_W-1:0] boot_addr,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              exc_valid,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_pc,
    output logic [XLEN-1:0]   pc_plus_inc,
    output logic              misalign_err
);

    pc_state_e       state_r, state_nxt_s;
    pend_src_e       pend_src_r, pend_src_nxt_s;
    logic [XLEN-1:0] pend_pc_r, pend_pc_nxt_s;
    logic            halt_pend_r, halt_pend_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic            req_r;
    logic            mis_r, mis_nxt_s;
    logic            load_pc_s;
    logic            advance_s;

    pend_src_e       live_src_s;
    logic [XLEN-1:0] live_pc_s;
    logic [XLEN-1:0] next_pc_s;
    logic            sel_mis_s;

    pc_next_sel #(
        .XLEN    (XLEN),
        .BOOT_W  (BOOT_W),
        .EXC_VEC (EXC_VEC),
        .INC     (INC)
    ) u_next_sel (
        .exc_valid      (exc_valid),
        .boot_load      (boot_load),
        .boot_addr      (boot_addr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pend_src       (pend_src_r),
        .pend_pc        (pend_pc_r),
        .cur_pc         (pc_r),
        .live_src       (live_src_s),
        .live_pc        (live_pc_s),
        .next_pc        (next_pc_s),
        .misalign       (sel_mis_s)
    );

    assign advance_s = req_r & imem_ready & ~stall;

    // Next-state, pending-slot and PC-load decisions.
    always_comb begin
        state_nxt_s     = state_r;
        pend_src_nxt_s  = pend_src_r;
        pend_pc_nxt_s   = pend_pc_r;
        halt_pend_nxt_s = halt_pend_r;
        mis_nxt_s       = 1'b0;
        load_pc_s       = 1'b0;
        case (state_r)
            ST_INIT: begin
                state_nxt_s = ST_FETCH;
                if (src_takes_over(live_src_s, pend_src_r)) begin
                    pend_src_nxt_s = live_src_s;
                    pend_pc_nxt_s  = live_pc_s;
                end else begin
                    pend_src_nxt_s = pend_src_r;
                    pend_pc_nxt_s  = pend_pc_r;
                end
            end
            ST_FETCH: begin
                if (advance_s) begin
                    load_pc_s      = 1'b1;
                    mis_nxt_s      = sel_mis_s;
                    pend_src_nxt_s = PEND_NONE;
                    pend_pc_nxt_s  = '0;
                    if (halt || halt_pend_r) begin
                        state_nxt_s     = ST_HALT;
                        halt_pend_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s     = ST_FETCH;
                        halt_pend_nxt_s = 1'b0;
                    end
                end else begin
                    // No handshake: remember halt and any event until the next advance.
                    halt_pend_nxt_s = halt_pend_r | halt;
                    if (src_takes_over(live_src_s, pend_src_r)) begin
                        pend_src_nxt_s = live_src_s;
                        pend_pc_nxt_s  = live_pc_s;
                    end else begin
                        pend_src_nxt_s = pend_src_r;
                        pend_pc_nxt_s  = pend_pc_r;
                    end
                end
            end
            ST_HALT: begin
                if (live_src_s != PEND_NONE) begin
                    load_pc_s   = 1'b1;
                    mis_nxt_s   = sel_mis_s;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s     = ST_INIT;
                pend_src_nxt_s  = PEND_NONE;
                pend_pc_nxt_s   = '0;
                halt_pend_nxt_s = 1'b0;
            end
        endcase
    end

    // State, pending slot and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_INIT;
            pend_src_r  <= PEND_NONE;
            pend_pc_r   <= '0;
            halt_pend_r <= 1'b0;
            pc_r        <= RESET_VEC;
            req_r       <= 1'b0;
            mis_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pend_src_r  <= pend_src_nxt_s;
            pend_pc_r   <= pend_pc_nxt_s;
            halt_pend_r <= halt_pend_nxt_s;
            req_r       <= (state_nxt_s == ST_FETCH);
            mis_r       <= mis_nxt_s;
            if (load_pc_s) begin
                pc_r <= next_pc_s;
            end else begin
                pc_r <= pc_r;
            end
        end
    end

    assign imem_req     = req_r;
    assign imem_pc      = pc_r;
    assign pc_plus_inc  = pc_r + XLEN'(INC);
    assign misalign_err = mis_r;

endmodule
